mips_main_control: RTL and testbench

- Multicycle MIPS main control unit: Moore FSM that sequences fetch/decode/execute/memory/writeback.
- Consumes the 6-bit opcode from the instruction register and drives datapath enables and muxes.
- Produces the 2-bit alu_op consumed by alu_control, which combines it with the funct field.
- Sits beside the datapath. Holds in memory states until the memory handshake completes.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/mips_ctrl_decode.sv | 94 +++++++++
 rtl/mips_main_control.sv | 105 ++++++++++
 tb/tb_mips_main_control.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS main control unit.
// Holds the state encoding, the opcode values and the datapath select codes.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_RST     = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_MEMADR  = 4'd3,
    ST_MEMRD   = 4'd4,
    ST_MEMWB   = 4'd5,
    ST_MEMWR   = 4'd6,
    ST_EXECUTE = 4'd7,
    ST_ALUWB   = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_ADDIEX  = 4'd10,
    ST_ADDIWB  = 4'd11,
    ST_JUMP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: is_legal_op = 1'b1;
      default:                                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control-word decoder for the main control FSM.
// Only FETCH (ready) and DECODE (opcode legality) look beyond the state.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic       ready,
  input  logic [5:0] op,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op
);

  // control word per state; anything not set for a state stays 0
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state)
      ST_FETCH: begin
        alu_src_b = SRCB_FOUR;
        if (ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        if (is_legal_op(op)) begin
          illegal_op = 1'b0;
        end else begin
          illegal_op = 1'b1;
        end
      end
      ST_MEMADR, ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: iord = 1'b1;
      ST_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      ST_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      ST_ADDIWB: reg_write = 1'b1;
      ST_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: state register and next-state logic.
// The control word itself comes from mips_ctrl_decode.
module mips_main_control
  import mips_pkg::*;
#(
  parameter bit WAIT_ON_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_t state_r;
  state_t next_s;
  logic   ready_s;

  assign ready_s = WAIT_ON_MEM ? mem_ready : 1'b1;
  assign state_o = state_r;

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RST;
    end else begin
      state_r <= next_s;
    end
  end

  // next-state logic; memory states hold until the handshake completes
  always_comb begin
    next_s = ST_FETCH;
    case (state_r)
      ST_RST:   next_s = ST_FETCH;
      ST_FETCH: begin
        if (ready_s) next_s = ST_DECODE;
        else         next_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_s = ST_MEMADR;
          OP_RTYPE:     next_s = ST_EXECUTE;
          OP_BEQ:       next_s = ST_BRANCH;
          OP_ADDI:      next_s = ST_ADDIEX;
          OP_J:         next_s = ST_JUMP;
          default:      next_s = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (op == OP_LW) next_s = ST_MEMRD;
        else             next_s = ST_MEMWR;
      end
      ST_MEMRD: begin
        if (ready_s) next_s = ST_MEMWB;
        else         next_s = ST_MEMRD;
      end
      ST_MEMWB: next_s = ST_FETCH;
      ST_MEMWR: begin
        if (ready_s) next_s = ST_FETCH;
        else         next_s = ST_MEMWR;
      end
      ST_EXECUTE: next_s = ST_ALUWB;
      ST_ALUWB:   next_s = ST_FETCH;
      ST_BRANCH:  next_s = ST_FETCH;
      ST_ADDIEX:  next_s = ST_ADDIWB;
      ST_ADDIWB:  next_s = ST_FETCH;
      ST_JUMP:    next_s = ST_FETCH;
      default:    next_s = ST_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state      (state_r),
    .ready      (ready_s),
    .op         (op),
    .pc_write   (pc_write),
    .branch     (branch),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op)
  );

endmodule

// File: tb/tb_mips_main_control.sv
// Directed bench for mips_main_control: every cycle compares state_o plus the
// full control word against hand-written expected words.
module tb_mips_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  mips_main_control #(.WAIT_ON_MEM(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op}
  logic [19:0] obs;
  assign obs = {state_o, pc_write, branch, iord, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op};

  function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, input logic br,
                                     input logic io, input logic mw, input logic irw,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic [1:0] ao,
                                     input logic ill);
    return {st, pcw, br, io, mw, irw, rd, m2r, rw, sa, sb, ps, ao, ill};
  endfunction

  logic [19:0] w_rst, w_fetch_r, w_fetch_w, w_decode, w_decode_ill, w_memadr, w_memrd;
  logic [19:0] w_memwb, w_memwr, w_exec, w_aluwb, w_branch, w_addiex, w_addiwb, w_jump;

  task automatic check_val(input string tag, input logic [19:0] got, input logic [19:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic step_check(input string tag, input logic [19:0] exp);
    @(posedge clk);
    #1;
    check_val(tag, obs, exp);
  endtask

  initial begin
    //              st    pcw br io mw irw rd m2r rw sa sb     ps     ao     ill
    w_rst        = mk(4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    w_fetch_r    = mk(4'd1,  1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    w_fetch_w    = mk(4'd1,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0);
    w_decode     = mk(4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0);
    w_decode_ill = mk(4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1);
    w_memadr     = mk(4'd3,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
    w_memrd      = mk(4'd4,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    w_memwb      = mk(4'd5,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    w_memwr      = mk(4'd6,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0);
    w_exec       = mk(4'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0);
    w_aluwb      = mk(4'd8,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    w_branch     = mk(4'd9,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0);
    w_addiex     = mk(4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0);
    w_addiwb     = mk(4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0);
    w_jump       = mk(4'd12, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0);

    // reset then lw
    rst_n = 1'b0; op = 6'b100011; mem_ready = 1'b1;
    step_check("rst0", w_rst);
    step_check("rst1", w_rst);
    rst_n = 1'b1;
    step_check("lw_fetch", w_fetch_r);
    step_check("lw_decode", w_decode);
    step_check("lw_memadr", w_memadr);
    step_check("lw_memrd", w_memrd);
    step_check("lw_memwb", w_memwb);
    step_check("lw_done", w_fetch_r);

    // sw with three wait cycles in MEMWR
    op = 6'b101011;
    step_check("sw_decode", w_decode);
    step_check("sw_memadr", w_memadr);
    mem_ready = 1'b0;
    step_check("sw_memwr1", w_memwr);
    step_check("sw_memwr2", w_memwr);
    step_check("sw_memwr3", w_memwr);
    step_check("sw_memwr4", w_memwr);
    mem_ready = 1'b1;
    step_check("sw_done", w_fetch_r);

    // R-type
    op = 6'b000000;
    step_check("r_decode", w_decode);
    step_check("r_exec", w_exec);
    step_check("r_aluwb", w_aluwb);
    step_check("r_done", w_fetch_r);

    // beq
    op = 6'b000100;
    step_check("beq_decode", w_decode);
    step_check("beq_branch", w_branch);
    step_check("beq_done", w_fetch_r);

    // addi
    op = 6'b001000;
    step_check("addi_decode", w_decode);
    step_check("addi_ex", w_addiex);
    step_check("addi_wb", w_addiwb);
    step_check("addi_done", w_fetch_r);

    // j
    op = 6'b000010;
    step_check("j_decode", w_decode);
    step_check("j_jump", w_jump);
    step_check("j_done", w_fetch_r);

    // fetch stall of five cycles, then the illegal opcode
    mem_ready = 1'b0; op = 6'b111111;
    #1;
    check_val("stall1", obs, w_fetch_w);
    for (int i = 0; i < 4; i++) step_check("stall_n", w_fetch_w);
    mem_ready = 1'b1;
    #1;
    check_val("stall_release", obs, w_fetch_r);
    step_check("ill_decode", w_decode_ill);
    step_check("ill_done", w_fetch_r);

    // reset in the middle of a stalled store
    op = 6'b101011;
    step_check("mr_decode", w_decode);
    step_check("mr_memadr", w_memadr);
    mem_ready = 1'b0;
    step_check("mr_memwr", w_memwr);
    rst_n = 1'b0;
    step_check("mr_rst", w_rst);
    rst_n = 1'b1;
    step_check("mr_fetch_wait", w_fetch_w);
    mem_ready = 1'b1;
    #1;
    check_val("mr_fetch_go", obs, w_fetch_r);
    step_check("mr_decode2", w_decode);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
